dot_acc16: RTL and testbench



---
 rtl/dot_acc16_pkg.sv | 16 +
 rtl/dot_acc16_cla16.sv | 45 ++++
 rtl/dot_acc16.sv | 106 ++++++++++
 tb/tb_dot_acc16.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_acc16_pkg.sv
// Shared constants for the dot_acc16 accumulator: data width and FSM encoding.
package dot_acc16_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC  = ST_ACC,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/dot_acc16_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second lookahead level.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gp[k] = &p[4*k +: 4];
    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);

    assign c[4*k]   = gc[k];
    assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
    assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
    assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                    | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
  end

  // Group carries are fully expanded so no carry ripples between groups.
  assign gc[0] = ci;
  assign gc[1] = gg[0] | (gp[0] & ci);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

  assign s  = p ^ c;
  assign co = gc[4];

endmodule

// File: rtl/dot_acc16.sv
// Sums N_TERMS unsigned 16-bit beats through one cla16 and presents one result per transaction.
module dot_acc16
  import dot_acc16_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(N_TERMS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  // Handshakes: a beat transfers on any edge where in_valid && in_ready; the result
  // is held while out_valid is high and is released by the first edge with out_ack.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] add_s;
  logic              add_co;
  logic              accept;

  cla16 U0_cla16 (
    .a  (acc_q),
    .b  (in_data),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_co;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are decoded from the next state so they are registered, not combinational.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dot_acc16.sv
// Bench for dot_acc16 at N_TERMS = 4, 1 and 16 against an integer-sum reference model.
module tb_dot_acc16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index 0: N_TERMS=4, 1: N_TERMS=1, 2: N_TERMS=16
  logic        start_a     [3];
  logic        in_valid_a  [3];
  logic        in_ready_a  [3];
  logic [15:0] in_data_a   [3];
  logic [15:0] out_sum_a   [3];
  logic        out_ovf_a   [3];
  logic        out_valid_a [3];
  logic        out_ack_a   [3];
  logic        busy_a      [3];

  dot_acc16 #(.N_TERMS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_a[0]), .in_data(in_data_a[0]),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .out_sum(out_sum_a[0]),
    .out_ovf(out_ovf_a[0]), .out_valid(out_valid_a[0]), .out_ack(out_ack_a[0]),
    .busy(busy_a[0]));

  dot_acc16 #(.N_TERMS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .in_data(in_data_a[1]),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .out_sum(out_sum_a[1]),
    .out_ovf(out_ovf_a[1]), .out_valid(out_valid_a[1]), .out_ack(out_ack_a[1]),
    .busy(busy_a[1]));

  dot_acc16 #(.N_TERMS(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_a[2]), .in_data(in_data_a[2]),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .out_sum(out_sum_a[2]),
    .out_ovf(out_ovf_a[2]), .out_valid(out_valid_a[2]), .out_ack(out_ack_a[2]),
    .busy(busy_a[2]));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  logic [15:0] beat_buf [16];
  int          gap_buf  [16];
  int          nterms   [3] = '{4, 1, 16};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: true integer sum of the beats; any carry happened iff it reached 2^16.
  task automatic model_push(input int n);
    longint tot = 0;
    for (int i = 0; i < n; i++) tot += longint'(beat_buf[i]);
    exp_q.push_back({(tot >= 65536) ? 1'b1 : 1'b0, tot[15:0]});
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_rdy"},   32'(in_ready_a[d]),  32'd0);
    check({tag, "_valid"}, 32'(out_valid_a[d]), 32'd0);
    check({tag, "_busy"},  32'(busy_a[d]),      32'd0);
  endtask

  // Called on a negedge with the DUT in IDLE; returns on a negedge with the DUT in IDLE.
  task automatic run_txn(input int d, input bit start_in_acc, input bit start_with_ack,
                         input int hold);
    int          n = nterms[d];
    logic [16:0] exp;
    model_push(n);
    check_idle(d, "pre");
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    check("acc_busy", 32'(busy_a[d]), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap_buf[i]; g++) begin
        in_valid_a[d] = 1'b0;
        in_data_a[d]  = 16'($urandom);
        out_ack_a[d]  = 1'($urandom_range(0, 1));
        check("gap_rdy", 32'(in_ready_a[d]), 32'd1);
        check("gap_valid", 32'(out_valid_a[d]), 32'd0);
        @(negedge clk);
      end
      out_ack_a[d]  = 1'b0;
      check("beat_rdy", 32'(in_ready_a[d]), 32'd1);
      in_valid_a[d] = 1'b1;
      in_data_a[d]  = beat_buf[i];
      start_a[d]    = start_in_acc && (i == 0);
      @(negedge clk);
      start_a[d]    = 1'b0;
    end
    in_valid_a[d] = 1'b0;
    in_data_a[d]  = 16'($urandom);
    exp = exp_q.pop_front();
    check("done_valid", 32'(out_valid_a[d]), 32'd1);
    check("done_rdy",   32'(in_ready_a[d]),  32'd0);
    check("done_busy",  32'(busy_a[d]),      32'd1);
    check("sum",        32'(out_sum_a[d]),   32'(exp[15:0]));
    check("ovf",        32'(out_ovf_a[d]),   32'(exp[16]));
    for (int h = 0; h < hold; h++) begin
      in_valid_a[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", 32'(out_valid_a[d]), 32'd1);
      check("hold_sum",   32'(out_sum_a[d]),   32'(exp[15:0]));
      check("hold_ovf",   32'(out_ovf_a[d]),   32'(exp[16]));
    end
    in_valid_a[d] = 1'b0;
    out_ack_a[d]  = 1'b1;
    start_a[d]    = start_with_ack;
    @(negedge clk);
    out_ack_a[d]  = 1'b0;
    start_a[d]    = 1'b0;
    check_idle(d, "ack");
    check("ack_sum", 32'(out_sum_a[d]), 32'(exp[15:0]));
  endtask

  task automatic fill(input logic [15:0] v, input int gap);
    for (int i = 0; i < 16; i++) begin
      beat_buf[i] = v;
      gap_buf[i]  = gap;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0; in_valid_a[d] = 1'b0; in_data_a[d] = '0; out_ack_a[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    start_a[0] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_idle(d, "rst");
      check("rst_sum", 32'(out_sum_a[d]), 32'd0);
      check("rst_ovf", 32'(out_ovf_a[d]), 32'd0);
    end
    @(negedge clk);
    start_a[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Beats 1,2,3,4 back to back
    fill(16'h0, 0);
    beat_buf[0] = 16'd1; beat_buf[1] = 16'd2; beat_buf[2] = 16'd3; beat_buf[3] = 16'd4;
    run_txn(0, 1'b0, 1'b0, 0);

    // Carry then small beats: sum wraps to 1, ovf sticks
    fill(16'h0, 0);
    beat_buf[0] = 16'hFFFF; beat_buf[1] = 16'h0002;
    run_txn(0, 1'b0, 1'b0, 1);

    // Gapped input: 5, idle 3, 5, 5, 5; start pulses in ACC and with the ack
    fill(16'd5, 0);
    gap_buf[1] = 3;
    run_txn(0, 1'b1, 1'b1, 2);

    // Fresh sum right after the previous one returned to IDLE
    fill(16'd9, 0);
    run_txn(0, 1'b0, 1'b0, 0);

    // Reset mid-ACC after two beats aborts with no result
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = 16'h4321;
      @(negedge clk);
    end
    in_valid_a[0] = 1'b0;
    check("pre_rst_sum", 32'(out_sum_a[0]), 32'h8642);
    reset = 1'b1;
    #1;
    check_idle(0, "mid_rst");
    check("mid_rst_sum", 32'(out_sum_a[0]), 32'd0);
    check("mid_rst_ovf", 32'(out_ovf_a[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle(0, "post_rst");
    fill(16'd7, 0);
    run_txn(0, 1'b0, 1'b0, 0);

    // Depth corner cases with 0x1000 beats
    fill(16'h1000, 0);
    run_txn(1, 1'b0, 1'b0, 1);
    run_txn(2, 1'b0, 1'b0, 1);

    // Randomised transactions on all three depths
    for (int t = 0; t < 30; t++) begin
      int d = $urandom_range(0, 2);
      bit big = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        beat_buf[i] = big ? 16'($urandom) : 16'($urandom_range(0, 255));
        gap_buf[i]  = $urandom_range(0, 2);
      end
      run_txn(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
